// File: rtl/usb_stream_pkg.sv
// Shared types and constants for the USB sample-stream arbiter.
package usb_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        MSB  = 2'd2,
        LSB  = 2'd3
    } state_t;

    localparam int unsigned PKT_BYTES            = 3;
    localparam logic [3:0]  HEADER_MAGIC_DEFAULT = 4'hA;

    // Header byte: magic nibble, three zero bits, then the channel ID.
    function automatic logic [7:0] make_header(input logic [3:0] magic, input logic ch);
        return {magic, 3'b000, ch};
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter with a one-hot grant and a remembered last winner.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       ack_i,
    output logic [1:0] grant_o
);

    logic last_grant_q;
    logic last_grant_d;

    // Grant: on contention pick the channel that did not win last; otherwise the lone requester.
    always_comb begin
        grant_o = 2'b00;
        if (req_i == 2'b11) begin
            grant_o = last_grant_q ? 2'b01 : 2'b10;
        end else begin
            grant_o = req_i;
        end
        last_grant_d = ack_i ? grant_o[1] : last_grant_q;
    end

    // Remember the accepted winner; reset favours channel 0 on first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/usb_stream_arbiter.sv
// Merges two 16-bit sample streams into 3-byte packets (header, MSB, LSB)
// for an FT232H byte FIFO sink, with round-robin arbitration and lossless backpressure.
module usb_stream_arbiter
    import usb_stream_pkg::*;
#(
    parameter logic [3:0]  HEADER_MAGIC = HEADER_MAGIC_DEFAULT,
    parameter int unsigned SAMPLE_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] ch0_tdata,
    input  logic                ch0_tvalid,
    output logic                ch0_tready,
    input  logic [SAMPLE_W-1:0] ch1_tdata,
    input  logic                ch1_tvalid,
    output logic                ch1_tready,
    output logic [7:0]          out_tdata,
    output logic                out_tvalid,
    input  logic                out_tready,
    output logic [15:0]         pkt_count
);

    state_t              state_q, state_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                ch_q, ch_d;
    logic [15:0]         pkt_count_q, pkt_count_d;
    logic [1:0]          grant;
    logic                in_hs;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req_i   ({ch1_tvalid, ch0_tvalid}),
        .ack_i   (in_hs),
        .grant_o (grant)
    );

    // Input readiness: only in IDLE, only for the granted channel, never during reset.
    always_comb begin
        ch0_tready = (state_q == IDLE) && !rst && grant[0];
        ch1_tready = (state_q == IDLE) && !rst && grant[1];
        in_hs      = (ch0_tvalid && ch0_tready) || (ch1_tvalid && ch1_tready);
    end

    // Packet FSM next state and byte output; bytes advance only on out_tready.
    always_comb begin
        state_d     = state_q;
        sample_d    = sample_q;
        ch_d        = ch_q;
        pkt_count_d = pkt_count_q;
        out_tvalid  = 1'b0;
        out_tdata   = 8'h00;
        case (state_q)
            IDLE: begin
                if (in_hs) begin
                    sample_d = ch1_tready ? ch1_tdata : ch0_tdata;
                    ch_d     = ch1_tready;
                    state_d  = HDR;
                end
            end
            HDR: begin
                out_tvalid = 1'b1;
                out_tdata  = make_header(HEADER_MAGIC, ch_q);
                if (out_tready) state_d = MSB;
            end
            MSB: begin
                out_tvalid = 1'b1;
                out_tdata  = sample_q[15:8];
                if (out_tready) state_d = LSB;
            end
            LSB: begin
                out_tvalid = 1'b1;
                out_tdata  = sample_q[7:0];
                if (out_tready) begin
                    state_d     = IDLE;
                    pkt_count_d = pkt_count_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, captured sample and packet counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sample_q    <= '0;
            ch_q        <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sample_q    <= sample_d;
            ch_q        <= ch_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_usb_stream_arbiter.sv
// Randomized and directed bench for usb_stream_arbiter against a queue-based packet model.
module tb_usb_stream_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ch0_tdata, ch1_tdata;
    logic        ch0_tvalid, ch1_tvalid;
    logic        ch0_tready, ch1_tready;
    logic [7:0]  out_tdata;
    logic        out_tvalid;
    logic        out_tready;
    logic [15:0] pkt_count;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Reference model: pending output bytes, completed-packet count, last winner.
    logic [7:0]  m_q[$];
    int unsigned m_count = 0;
    int unsigned m_last  = 1;

    always #5 clk = ~clk;

    usb_stream_arbiter #(
        .HEADER_MAGIC (4'hA),
        .SAMPLE_W     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ch0_tdata  (ch0_tdata),
        .ch0_tvalid (ch0_tvalid),
        .ch0_tready (ch0_tready),
        .ch1_tdata  (ch1_tdata),
        .ch1_tvalid (ch1_tvalid),
        .ch1_tready (ch1_tready),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .pkt_count  (pkt_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance the model.
    task automatic step(input logic v0, input logic [15:0] d0, input logic v1,
                        input logic [15:0] d1, input logic ordy, input logic r);
        int g;
        logic [15:0] s;
        @(negedge clk);
        ch0_tvalid = v0; ch0_tdata = d0;
        ch1_tvalid = v1; ch1_tdata = d1;
        out_tready = ordy; rst = r;
        #1;
        g = -1;
        if (!r && m_q.size() == 0) begin
            if (v0 && v1)  g = (m_last == 1) ? 0 : 1;
            else if (v0)   g = 0;
            else if (v1)   g = 1;
        end
        chk("ch0_tready", 32'(ch0_tready), 32'(g == 0));
        chk("ch1_tready", 32'(ch1_tready), 32'(g == 1));
        chk("out_tvalid", 32'(out_tvalid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("out_tdata", 32'(out_tdata), 32'(m_q[0]));
        chk("pkt_count", 32'(pkt_count), m_count);
        if (r) begin
            m_q.delete();
            m_count = 0;
            m_last  = 1;
        end else if (m_q.size() == 0) begin
            if (g >= 0) begin
                s = (g == 1) ? d1 : d0;
                m_q.push_back({4'hA, 3'b000, g[0]});
                m_q.push_back(s[15:8]);
                m_q.push_back(s[7:0]);
                m_last = g;
            end
        end else if (ordy) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_count = (m_count + 1) % 65536;
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    logic [7:0] hdr_exp[3];

    initial begin
        rst = 1'b1; ch0_tvalid = 1'b0; ch1_tvalid = 1'b0;
        ch0_tdata = '0; ch1_tdata = '0; out_tready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        step(1'b1, 16'h1234, 1'b1, 16'h5678, 1'b1, 1'b1);
        chk("rst_ready0", 32'(ch0_tready), 32'd0);
        chk("rst_ready1", 32'(ch1_tready), 32'd0);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("rst_tvalid", 32'(out_tvalid), 32'd0);
        chk("rst_tdata", 32'(out_tdata), 32'h00);
        chk("rst_count", 32'(pkt_count), 32'd0);

        // Single channel 0ABC
        step(1'b1, 16'h0ABC, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("single_hdr", 32'(out_tdata), 32'hA0);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("single_msb", 32'(out_tdata), 32'h0A);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("single_lsb", 32'(out_tdata), 32'hBC);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("single_count", 32'(pkt_count), 32'd1);

        // Contention after reset: ch0, ch1, ch0
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1);
        hdr_exp[0] = 8'hA0; hdr_exp[1] = 8'hA1; hdr_exp[2] = 8'hA0;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 16'h0111, 1'b1, 16'h0222, 1'b1, 1'b0);
            step(1'b1, 16'h0111, 1'b1, 16'h0222, 1'b1, 1'b0);
            chk("contend_hdr", 32'(out_tdata), 32'(hdr_exp[k]));
            step(1'b1, 16'h0111, 1'b1, 16'h0222, 1'b1, 1'b0);
            step(1'b1, 16'h0111, 1'b1, 16'h0222, 1'b1, 1'b0);
        end
        idle_steps(2);

        // Backpressure during MSB
        step(1'b1, 16'hC35A, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
            chk("stall_msb", 32'(out_tdata), 32'hC3);
        end
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("stall_lsb", 32'(out_tdata), 32'h5A);
        idle_steps(1);

        // Reset during LSB
        step(1'b0, 16'h0, 1'b1, 16'h7E81, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1);
        step(1'b1, 16'h1111, 1'b1, 16'h2222, 1'b1, 1'b0);
        chk("midrst_tvalid", 32'(out_tvalid), 32'd0);
        chk("midrst_count", 32'(pkt_count), 32'd0);
        chk("midrst_grant0", 32'(ch0_tready), 32'd1);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("midrst_hdr", 32'(out_tdata), 32'hA0);
        idle_steps(3);

        // Valid withdrawal while in MSB
        step(1'b1, 16'hBEEF, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b1, 16'h4242, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("withdraw_idle", 32'(out_tvalid), 32'd0);

        // Counter wrap: preload 16'hFFFF, then complete one packet
        force dut.pkt_count_q = 16'hFFFF;
        m_count = 65535;
        idle_steps(1);
        release dut.pkt_count_q;
        step(1'b0, 16'h0, 1'b1, 16'h9999, 1'b1, 1'b0);
        idle_steps(4);
        chk("wrap_count", 32'(pkt_count), 32'd0);

        // Randomized traffic with random backpressure and rare resets
        for (int i = 0; i < 4000; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                 16'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_stream_arbiter.md
USB_STREAM_ARBITER -- requirements
Module: usb_stream_arbiter

Interface
REQ-001 Parameter HEADER_MAGIC, default 4'hA, SHALL be the upper nibble of every packet header byte.
REQ-002 Parameter SAMPLE_W, default 16, SHALL be the input sample width; only 16 is supported.
REQ-003 clk  input  1  SHALL be the single clock of the block; all logic is synchronous to its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 ch0_tdata  input  16  SHALL carry a channel-0 sample, zero-extended to 16 bits.
REQ-006 ch0_tvalid  input  1  SHALL indicate that the channel-0 sample is valid.
REQ-007 ch0_tready  output  1  SHALL indicate that the block accepts the channel-0 sample.
REQ-008 ch1_tdata, ch1_tvalid, ch1_tready SHALL be identical in direction, width and meaning to the channel-0 ports, for channel 1.
REQ-009 out_tdata  output  8  SHALL carry the byte stream toward the FT232H FIFO sink.
REQ-010 out_tvalid  output  1  SHALL mark out_tdata as valid.
REQ-011 out_tready  input  1  SHALL be the backpressure signal from the FIFO sink.
REQ-012 pkt_count  output  16  SHALL count completed packets.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, HDR, MSB, LSB.
REQ-014 ch0_tready and ch1_tready SHALL be combinational and SHALL be high only in IDLE, for the granted channel only.
REQ-015 Grant SHALL be round-robin:
- both channels valid: the channel not granted last;
- one channel valid: that channel.
REQ-016 last_grant SHALL reset to 1, so that channel 0 wins the first contention.
REQ-017 On an input handshake (tvalid && tready) the block SHALL:
- capture the sample and channel ID;
- update last_grant;
- go to HDR with out_tvalid=1 on the next cycle.
REQ-018 Packet format SHALL be 3 bytes, in order:
- HDR = {HEADER_MAGIC, 3'b000, ch};
- MSB = sample[15:8];
- LSB = sample[7:0].
REQ-019 In HDR, MSB and LSB, out_tvalid SHALL be 1, and out_tdata SHALL stay stable until out_tready=1.
REQ-020 On an output handshake the FSM SHALL advance: HDR->MSB, MSB->LSB, LSB->IDLE.
REQ-021 The LSB handshake SHALL deassert out_tvalid in the following IDLE cycle.
REQ-022 The LSB handshake SHALL increment pkt_count modulo 2^16; 16'hFFFF SHALL wrap to 0.
REQ-023 Timing: minimum 4 cycles per packet (capture plus 3 bytes); no input SHALL be accepted outside IDLE.
REQ-024 out_tready low SHALL stall the FSM indefinitely with no byte loss or duplication.
REQ-025 A tvalid deasserted before its handshake SHALL cause no capture; arbitration SHALL be re-evaluated every IDLE cycle.
REQ-026 Backpressure SHALL be lossless: samples are never dropped, only stalled at the source.

Reset
REQ-027 Reset SHALL set:
- state to IDLE;
- out_tvalid=0, out_tdata=8'h00;
- pkt_count=0, last_grant=1;
- the captured sample register to 0.
REQ-028 Reset asserted mid-packet SHALL discard the partial packet; no further bytes of it SHALL be emitted.
REQ-029 ch0_tready and ch1_tready SHALL be 0 while rst=1.

Structure
REQ-030 Package usb_stream_pkg SHALL hold:
- the state_t enum;
- PKT_BYTES=3;
- the HEADER_MAGIC default.
REQ-031 Round-robin grant logic SHALL be a sub-module rr_arbiter2 (2 requests, 1-hot grant, last_grant register).
REQ-032 The block SHALL be instantiable directly upstream of ft232h, whose sys_axis Sink is driven by out_*.

Verification
REQ-033 Single channel: ch0 sends 16'h0ABC with out_tready=1 -> bytes A0, 0A, BC on consecutive cycles; pkt_count=1.
REQ-034 Contention: both channels valid continuously, ch0=16'h0111, ch1=16'h0222 -> packets alternate ch0, ch1, ch0; headers A0, A1, A0.
REQ-035 Backpressure: out_tready low for 5 cycles during MSB -> out_tdata held at MSB; the stream resumes with no duplicate byte.
REQ-036 Reset mid-packet: rst pulsed during LSB -> out_tvalid=0 the next cycle, pkt_count=0, and the next header comes from ch0.
REQ-037 Wrap: force 65536 packets -> pkt_count returns to 0.
REQ-038 Valid withdrawal: ch1_tvalid pulses one cycle while FSM is in MSB -> no capture and no ch1 packet.
